// File: rtl/noc_input_buffer.sv
// noc_fifo: generic show-ahead FIFO with occupancy count, head zeroed when empty.
// Latency: an entry written on edge N is visible on pop_dat after edge N.
// Backpressure: push_rdy is derived from registered count and rst only, never from pop_rdy.
module noc_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is deliberately left unreset; stale contents are never visible because
  // pop_dat is forced to zero whenever the FIFO is empty.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Ready looks only at state and rst, so a full FIFO never falls through.
  assign push_rdy = !rst && (count != FULL_CNT);
  assign pop_vld  = (count != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  // Write the accepted entry at the tail; push is already blocked during rst.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// noc_input_buffer: per-port input flit buffer sitting directly upstream of xy_router.
// Latency: a flit accepted from the link on edge N is presented to the router after edge N.
// Backpressure: link_ready depends on occupancy only; a stalled router holds the head flit stable.
module noc_input_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] link_data,
  input  logic [ADDR_WIDTH-1:0] link_addr,
  input  logic                  link_valid,
  output logic                  link_ready,
  output logic [DATA_WIDTH-1:0] rtr_data,
  output logic [ADDR_WIDTH-1:0] rtr_addr,
  output logic                  rtr_valid,
  input  logic                  rtr_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;

  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(DEPTH - 1);

  flit_t in_flit_dat;
  flit_t head_flit_dat;

  assign in_flit_dat.addr = link_addr;
  assign in_flit_dat.data = link_data;

  noc_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (link_valid),
    .push_dat (in_flit_dat),
    .push_rdy (link_ready),
    .pop_vld  (rtr_valid),
    .pop_dat  (head_flit_dat),
    .pop_rdy  (rtr_ready),
    .count    (count)
  );

  // Head flit is already zeroed by the FIFO when empty.
  assign rtr_data    = head_flit_dat.data;
  assign rtr_addr    = head_flit_dat.addr;
  assign almost_full = (count >= AF_CNT);

endmodule
